// File: rtl/antares_alu_pkg.sv
// Shared constants for the Antares-R2 ALU path: default width, flag bit positions and
// saturation bounds (bounds valid for widths up to SAT_MAX_WIDTH).
package antares_alu_pkg;
    localparam int ALU_WIDTH     = 32;
    localparam int FLAG_C        = 0;
    localparam int FLAG_V        = 1;
    localparam int FLAG_Z        = 2;
    localparam int NUM_FLAGS     = 3;
    localparam int SAT_MAX_WIDTH = 64;

    // Largest positive two's-complement value of a w-bit word, zero-extended.
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_pos(input int w);
        return (SAT_MAX_WIDTH'(1) << (w - 1)) - SAT_MAX_WIDTH'(1);
    endfunction

    // Most negative two's-complement value of a w-bit word, zero-extended.
    function automatic logic [SAT_MAX_WIDTH-1:0] sat_neg(input int w);
        return SAT_MAX_WIDTH'(1) << (w - 1);
    endfunction
endpackage

// File: rtl/adder_slice.sv
// Combinational ripple-carry slice of SW full-adder cells. Exposes the carry into the
// slice MSB so the top slice can derive signed overflow.
module adder_slice #(
    parameter int SW = 8
) (
    input  logic [SW-1:0] a_i,
    input  logic [SW-1:0] b_i,
    input  logic          cin_i,
    output logic [SW-1:0] sum_o,
    output logic          cout_o,
    output logic          cmsb_o
);
    logic [SW:0] carry;

    always_comb begin
        carry    = '0;
        sum_o    = '0;
        carry[0] = cin_i;
        for (int i = 0; i < SW; i++) begin
            sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign cout_o = carry[SW];
    assign cmsb_o = carry[SW-1];
endmodule

// File: rtl/pipelined_adder.sv
// STAGES-deep add/subtract pipeline, one carry-chain slice per stage, valid/ready both sides.
// Optional saturation (input SatEn) is built when PIPELINED_ADDER_SAT_EN is defined.
module pipelined_adder
    import antares_alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
`ifdef PIPELINED_ADDER_SAT_EN
    input  logic             SatEn,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);
    localparam int SW = WIDTH / STAGES;

    // Stage k holds operands (for the slices still to come), the partial result built so far
    // and the carry out of slice k.
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic [STAGES-1:0]            c_q, c_d, v_q, v_d;
    logic [NUM_FLAGS-1:0]         flags_q, flags_d;
    logic                         advance;

`ifdef PIPELINED_ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
    logic [STAGES-1:0] sat_q, sat_d;
`endif

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] a_in, b_in, s_in, merged;
        logic             c_in;
        logic [SW-1:0]    slice_sum;
        logic             slice_cout, slice_cmsb;
`ifdef PIPELINED_ADDER_SAT_EN
        logic             sat_in;
`endif

        if (gi == 0) begin : g_first
            assign a_in      = A;
            assign b_in      = Sub ? ~B : B;
            assign c_in      = Cin ^ Sub;
            assign s_in      = '0;
            assign v_d[gi]   = in_valid;
`ifdef PIPELINED_ADDER_SAT_EN
            assign sat_in    = SatEn;
`endif
        end else begin : g_next
            assign a_in      = a_q[gi-1];
            assign b_in      = b_q[gi-1];
            assign c_in      = c_q[gi-1];
            assign s_in      = s_q[gi-1];
            assign v_d[gi]   = v_q[gi-1];
`ifdef PIPELINED_ADDER_SAT_EN
            assign sat_in    = sat_q[gi-1];
`endif
        end

        adder_slice #(.SW(SW)) u_slice (
            .a_i    (a_in[gi*SW +: SW]),
            .b_i    (b_in[gi*SW +: SW]),
            .cin_i  (c_in),
            .sum_o  (slice_sum),
            .cout_o (slice_cout),
            .cmsb_o (slice_cmsb)
        );

        assign merged  = (s_in & ~(WIDTH'({SW{1'b1}}) << (gi*SW)))
                       | (WIDTH'(slice_sum) << (gi*SW));
        assign a_d[gi] = a_in;
        assign b_d[gi] = b_in;
        assign c_d[gi] = slice_cout;
`ifdef PIPELINED_ADDER_SAT_EN
        assign sat_d[gi] = sat_in;
`endif

        if (gi == STAGES - 1) begin : g_last
            logic             ovf;
            logic [WIDTH-1:0] result;
            assign ovf = slice_cmsb ^ slice_cout;
`ifdef PIPELINED_ADDER_SAT_EN
            // Overflow direction follows A's sign: A >= 0 can only overflow upward.
            assign result = (sat_in && ovf) ? (a_in[WIDTH-1] ? SAT_NEG : SAT_POS) : merged;
`else
            assign result = merged;
`endif
            assign s_d[gi]         = result;
            assign flags_d[FLAG_C] = slice_cout;
            assign flags_d[FLAG_V] = ovf;
            assign flags_d[FLAG_Z] = (result == '0);
        end else begin : g_mid
            logic unused_cmsb;
            assign unused_cmsb = slice_cmsb;
            assign s_d[gi]     = merged;
        end
    end

    // The last stage's operand/carry copies have no consumer; synthesis trims them.
    logic unused_tail;
`ifdef PIPELINED_ADDER_SAT_EN
    assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], c_q[STAGES-1], sat_q[STAGES-1]};
`else
    assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], c_q[STAGES-1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= '0;
            v_q     <= '0;
            flags_q <= '0;
`ifdef PIPELINED_ADDER_SAT_EN
            sat_q   <= '0;
`endif
        end else if (advance) begin
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            v_q     <= v_d;
            flags_q <= flags_d;
`ifdef PIPELINED_ADDER_SAT_EN
            sat_q   <= sat_d;
`endif
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign Sum       = s_q[STAGES-1];
    assign Cout      = flags_q[FLAG_C];
    assign Ovf       = flags_q[FLAG_V];
    assign Zero      = flags_q[FLAG_Z];
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed corner ops, reset, back-pressure, bubbles
// and randomized streams scored against an arithmetic model.
module tb_pipelined_adder;
    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
`ifdef PIPELINED_ADDER_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             Cin = 1'b0;
    logic             Sub = 1'b0;
    logic             sat_en = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] Sum;
    logic             Cout, Ovf, Zero;

    int checks   = 0;
    int failures = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .Sub       (Sub),
`ifdef PIPELINED_ADDER_SAT_EN
        .SatEn     (sat_en),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .Zero      (Zero)
    );

    // Reference: plain wide arithmetic; signed overflow from operand/result signs.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub, input logic sat);
        logic [WIDTH-1:0] bx;
        logic [WIDTH:0]   t;
        res_t             r;
        bx     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(cin ^ sub);
        r.sum  = t[WIDTH-1:0];
        r.cout = t[WIDTH];
        r.ovf  = (a[WIDTH-1] == bx[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
        if (SAT_BUILD && sat && r.ovf)
            r.sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_res(input string name, input res_t act, input res_t exp);
        check({name, ".sum"},  64'(act.sum),  64'(exp.sum));
        check({name, ".cout"}, 64'(act.cout), 64'(exp.cout));
        check({name, ".ovf"},  64'(act.ovf),  64'(exp.ovf));
        check({name, ".zero"}, 64'(act.zero), 64'(exp.zero));
    endtask

    // Compare process: handshake rule, stall stability and in-order scoreboard, every cycle.
    logic hold_v = 1'b0;
    res_t hold_r;
    always @(negedge clk) begin
        res_t cur, e;
        cur = '{sum: Sum, cout: Cout, ovf: Ovf, zero: Zero};
        if (!rst_n) begin
            sb.delete();
            hold_v = 1'b0;
        end else begin
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (hold_v) begin
                check("stall.valid", 64'(out_valid), 64'd1);
                check_res("stall", cur, hold_r);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb.unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_res("sb", cur, e);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_r = cur;
            if (in_valid && in_ready)
                sb.push_back(model(A, B, Cin, Sub, sat_en));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic rand_op();
        A      = pick();
        B      = pick();
        Cin    = 1'($urandom);
        Sub    = 1'($urandom);
        sat_en = 1'($urandom);
    endtask

    // Single op into an empty pipe: measures latency and checks against literal expectations.
    task automatic directed(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub, input logic sat, input res_t exp);
        int lat;
        A = a; B = b; Cin = cin; Sub = sub; sat_en = sat;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        check({name, ".latency"}, 64'(lat), 64'(STAGES));
        check_res(name, '{sum: Sum, cout: Cout, ovf: Ovf, zero: Zero}, exp);
        $display("op %s: A=%h B=%h Cin=%0b Sub=%0b -> Sum=%h C=%0b V=%0b Z=%0b lat=%0d",
                 name, a, b, cin, sub, Sum, Cout, Ovf, Zero, lat);
        tick();
    endtask

    // Stream nops operands; bp_window forces out_ready=0 on cycles 5..7.
    task automatic stream(input int nops, input int valid_pct, input int ready_pct, input bit bp_window);
        int   sent = 0;
        int   cyc  = 0;
        logic acc  = 1'b1;
        in_valid = 1'b0;
        while (sent < nops && cyc < 60000) begin
            out_ready = bp_window ? !(cyc >= 5 && cyc <= 7) : ($urandom_range(99) < ready_pct);
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(99) < valid_pct);
                if (in_valid) rand_op();
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (bp_window && cyc >= 5 && cyc <= 7 && out_valid)
                check("bp.in_ready_low", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
        end
        check("stream.all_sent", 64'(sent), 64'(nops));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        check("drain.scoreboard_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic inv [16];
        logic outv[16];
        res_t r;

        // Model pinned against hand-computed values.
        r = model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        check_res("pin.ffff+1", r, '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1});
        r = model(32'h5, 32'h7, 1'b0, 1'b1, 1'b0);
        check_res("pin.5-7", r, '{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
        r = model(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b0);
        check_res("pin.min-1", r, '{sum: 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0});

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.sum", 64'(Sum), 64'd0);
        check("reset.flags", 64'({Cout, Ovf, Zero}), 64'd0);
        rst_n = 1'b1;
        tick();
        check("reset.in_ready", 64'(in_ready), 64'd1);

        // Directed corner ops.
        directed("ripple_all", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0,
                 '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1});
        directed("sub_5_7", 32'h5, 32'h7, 1'b0, 1'b1, 1'b0,
                 '{sum: 32'hFFFF_FFFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0});
        directed("sub_min_1", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1,
                 '{sum: SAT_BUILD ? 32'h8000_0000 : 32'h7FFF_FFFF, cout: 1'b1, ovf: 1'b1, zero: 1'b0});
        directed("add_max_1", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1,
                 '{sum: SAT_BUILD ? 32'h7FFF_FFFF : 32'h8000_0000, cout: 1'b0, ovf: 1'b1, zero: 1'b0});
        directed("sub_0_0", 32'h0, 32'h0, 1'b0, 1'b1, 1'b0,
                 '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, zero: 1'b1});
        directed("add_cin", 32'h0000_FFFF, 32'h0, 1'b1, 1'b0, 1'b0,
                 '{sum: 32'h0001_0000, cout: 1'b0, ovf: 1'b0, zero: 1'b0});

        // Reset with ops in flight and a held result on the output.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_op();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("midreset.pre_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset.out_valid", 64'(out_valid), 64'd0);
        check("midreset.sum", 64'(Sum), 64'd0);
        check("midreset.flags", 64'({Cout, Ovf, Zero}), 64'd0);
        check("midreset.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midreset.no_stale", 64'(out_valid), 64'd0);
        end

        // Back-pressure: 8 ops, consumer stalls on cycles 5..7.
        stream(8, 100, 100, 1'b1);
        drain();

        // Bubbles: accept pattern must reappear on out_valid STAGES cycles later.
        out_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            in_valid = (t < 6) ? (t % 2 == 0) : 1'b0;
            if (in_valid) rand_op();
            @(negedge clk);
            inv[t]  = in_valid;
            outv[t] = out_valid;
            tick();
        end
        for (int t = 0; t < STAGES; t++)
            check($sformatf("bubble.lead%0d", t), 64'(outv[t]), 64'd0);
        for (int t = 0; t + STAGES < 16; t++)
            check($sformatf("bubble.t%0d", t), 64'(outv[t + STAGES]), 64'(inv[t]));
        drain();

        // Randomized streams: full rate, mixed, sparse (10k ops total).
        stream(2000, 100, 100, 1'b0);
        drain();
        stream(6000, 70, 70, 1'b0);
        drain();
        stream(2000, 30, 50, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
